// File: rtl/mmcm_drp_sequencer.sv
// Walks a table of DRP read-modify-write entries into an MMCM while holding it
// in reset, then releases the reset and waits for a synchronized LOCKED.
module mmcm_drp_sequencer #(
  parameter int NUM_ENTRIES  = 8,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RST_HOLD     = 4
) (
  input  logic        clk_in1,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [3:0]  tbl_idx,
  input  logic [6:0]  tbl_addr,
  input  logic [15:0] tbl_mask,
  input  logic [15:0] tbl_data,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        locked_sync
);

  localparam int STEP_MAX = (DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);
  localparam int LOCK_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [STEP_W-1:0] HOLD_LAST = STEP_W'(RST_HOLD - 1);
  localparam logic [STEP_W-1:0] DRDY_LAST = STEP_W'(DRDY_TIMEOUT - 1);
  localparam logic [STEP_W-1:0] STEP_SAT  = STEP_W'(STEP_MAX);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
  localparam logic [LOCK_W-1:0] LOCK_SAT  = LOCK_W'(LOCK_TIMEOUT);
  localparam logic [3:0]        LAST_IDX  = 4'(NUM_ENTRIES - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_ASSERT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_NEXT,
    ST_RST_RELEASE,
    ST_WAIT_LOCK,
    ST_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [3:0]         tbl_idx_q, tbl_idx_d;
  logic [6:0]         daddr_q, daddr_d;
  logic [15:0]        di_q, di_d;
  logic               den_q, den_d;
  logic               dwe_q, dwe_d;
  logic               mmcm_rst_q, mmcm_rst_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [15:0]        word_q, word_d;
  logic               sync1_q, sync2_q;

  logic [15:0]        merged_word;
  logic [STEP_W-1:0]  step_inc;
  logic [LOCK_W-1:0]  lock_inc;

  // Bits under the mask keep the MMCM's current value; the rest take table data.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_merge
      assign merged_word[gi] = tbl_mask[gi] ? drp_do[gi] : tbl_data[gi];
    end
  endgenerate

  assign step_inc = (step_cnt_q == STEP_SAT) ? step_cnt_q : step_cnt_q + 1'b1;
  assign lock_inc = (lock_cnt_q == LOCK_SAT) ? lock_cnt_q : lock_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    err_code_d = err_code_q;
    tbl_idx_d  = tbl_idx_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    mmcm_rst_d = mmcm_rst_q;
    step_cnt_d = step_cnt_q;
    lock_cnt_d = lock_cnt_q;
    word_d     = word_q;

    case (state_q)
      ST_IDLE: begin
        busy_d     = 1'b0;
        mmcm_rst_d = 1'b0;
        // The done cycle is still part of the finished run, so a start there is dropped.
        if (start && !done_q) begin
          state_d    = ST_RST_ASSERT;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          err_code_d = 2'd0;
          tbl_idx_d  = 4'd0;
          mmcm_rst_d = 1'b1;
          step_cnt_d = '0;
        end
      end
      ST_RST_ASSERT: begin
        if (step_cnt_q == HOLD_LAST) begin
          state_d = ST_RD_REQ;
        end else begin
          step_cnt_d = step_inc;
        end
      end
      ST_RD_REQ: begin
        den_d      = 1'b1;
        daddr_d    = tbl_addr;
        step_cnt_d = '0;
        state_d    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // The first wait cycle carries DEN itself; DRDY there is not a response.
        if (!den_q) begin
          if (drp_drdy) begin
            word_d  = merged_word;
            state_d = ST_WR_REQ;
          end else if (step_cnt_q == DRDY_LAST) begin
            state_d    = ST_FAIL;
            error_d    = 1'b1;
            err_code_d = 2'd1;
            mmcm_rst_d = 1'b0;
          end else begin
            step_cnt_d = step_inc;
          end
        end
      end
      ST_WR_REQ: begin
        den_d      = 1'b1;
        dwe_d      = 1'b1;
        di_d       = word_q;
        step_cnt_d = '0;
        state_d    = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (!den_q) begin
          if (drp_drdy) begin
            state_d = ST_NEXT;
          end else if (step_cnt_q == DRDY_LAST) begin
            state_d    = ST_FAIL;
            error_d    = 1'b1;
            err_code_d = 2'd1;
            mmcm_rst_d = 1'b0;
          end else begin
            step_cnt_d = step_inc;
          end
        end
      end
      ST_NEXT: begin
        if (tbl_idx_q == LAST_IDX) begin
          state_d    = ST_RST_RELEASE;
          mmcm_rst_d = 1'b0;
        end else begin
          tbl_idx_d = tbl_idx_q + 4'd1;
          state_d   = ST_RD_REQ;
        end
      end
      ST_RST_RELEASE: begin
        lock_cnt_d = '0;
        state_d    = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (sync2_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d    = ST_FAIL;
          error_d    = 1'b1;
          err_code_d = 2'd2;
          mmcm_rst_d = 1'b0;
        end else begin
          lock_cnt_d = lock_inc;
        end
      end
      ST_FAIL: begin
        busy_d     = 1'b0;
        mmcm_rst_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
      tbl_idx_q  <= 4'd0;
      daddr_q    <= 7'd0;
      di_q       <= 16'd0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      mmcm_rst_q <= 1'b0;
      step_cnt_q <= '0;
      lock_cnt_q <= '0;
      word_q     <= 16'd0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      tbl_idx_q  <= tbl_idx_d;
      daddr_q    <= daddr_d;
      di_q       <= di_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      mmcm_rst_q <= mmcm_rst_d;
      step_cnt_q <= step_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      word_q     <= word_d;
      sync1_q    <= mmcm_locked;
      sync2_q    <= sync1_q;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;
  assign tbl_idx     = tbl_idx_q;
  assign drp_daddr   = daddr_q;
  assign drp_di      = di_q;
  assign drp_den     = den_q;
  assign drp_dwe     = dwe_q;
  // The MMCM is held in reset for as long as the sequencer itself is.
  assign mmcm_rst    = mmcm_rst_q | reset;
  assign locked_sync = sync2_q;

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Bench for mmcm_drp_sequencer: table of reconfiguration vectors with a DRP
// responder, lock model and write scoreboard, plus timeout and reset cases.
module tb_mmcm_drp_sequencer;

  logic        clk_in1 = 1'b0;
  logic        reset, start;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [3:0]  tbl_idx;
  logic [6:0]  tbl_addr;
  logic [15:0] tbl_mask, tbl_data;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di, drp_do;
  logic        drp_den, drp_dwe, drp_drdy;
  logic        mmcm_rst, mmcm_locked, locked_sync;

  mmcm_drp_sequencer #(
    .NUM_ENTRIES(2), .DRDY_TIMEOUT(64), .LOCK_TIMEOUT(65536), .RST_HOLD(4)
  ) dut (
    .clk_in1(clk_in1), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_mask(tbl_mask), .tbl_data(tbl_data),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked), .locked_sync(locked_sync)
  );

  initial forever #5 clk_in1 = ~clk_in1;

  // Two-entry table, DRP read value, hand-computed write words, DRDY latency.
  typedef struct {
    logic [6:0]  a0; logic [15:0] m0; logic [15:0] d0; logic [15:0] e0;
    logic [6:0]  a1; logic [15:0] m1; logic [15:0] d1; logic [15:0] e1;
    logic [15:0] rd; int lat; bit spur;
  } vec_t;

  typedef struct {
    logic [6:0] addr; logic [15:0] data; int rd_cyc;
  } exp_t;

  vec_t vecs[4];
  vec_t cur;
  exp_t sb_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, pend = 0, lk = 0, lock_delay = 20;
  bit resp_en = 1'b1, lock_en = 1'b1;
  int rd_seen = 0, wr_seen = 0, done_cnt = 0;
  int first_rd_cyc = 0, rst_rise_cyc = 0, rst_fall_cyc = 0, err_rise_cyc = 0;
  logic prev_den = 1'b0, prev_rst = 1'b0, prev_err = 1'b0;

  assign tbl_addr = (tbl_idx == 4'd0) ? cur.a0 : cur.a1;
  assign tbl_mask = (tbl_idx == 4'd0) ? cur.m0 : cur.m1;
  assign tbl_data = (tbl_idx == 4'd0) ? cur.d0 : cur.d1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // One clock: sample on the falling edge, run the DRP/lock models and the monitor.
  task automatic tick();
    exp_t e;
    logic [6:0]  ea;
    logic [15:0] ed;
    @(negedge clk_in1);
    cyc++;
    drp_drdy = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drp_drdy = 1'b1;
        drp_do   = cur.rd;
      end
    end
    if (drp_den && resp_en) begin
      pend = cur.lat;
      if (cur.spur) begin
        drp_drdy = 1'b1;
        drp_do   = ~cur.rd;
      end
    end
    if (mmcm_rst) begin
      lk = 0;
      mmcm_locked = 1'b0;
    end else if (lock_en) begin
      if (lk < lock_delay) lk++;
      mmcm_locked = (lk >= lock_delay);
    end else begin
      mmcm_locked = 1'b0;
    end

    if (drp_den) begin
      chk("den_back_to_back", prev_den, 1'b0);
      chk("den_without_mmcm_rst", mmcm_rst, 1'b1);
      if (!drp_dwe) begin
        ea = (rd_seen == 0) ? cur.a0 : cur.a1;
        ed = (rd_seen == 0) ? cur.e0 : cur.e1;
        chk("rd_addr", drp_daddr, ea);
        if (rd_seen == 0) first_rd_cyc = cyc;
        sb_q.push_back('{addr: ea, data: ed, rd_cyc: cyc});
        rd_seen++;
      end else begin
        chk("wr_pending", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("wr_addr", drp_daddr, e.addr);
          chk("wr_data", drp_di, e.data);
          chk("wr_latency", cyc - e.rd_cyc, cur.lat + 2);
        end
        wr_seen++;
      end
    end
    if (done) done_cnt++;
    if (!prev_rst && mmcm_rst) rst_rise_cyc = cyc;
    if (prev_rst && !mmcm_rst) rst_fall_cyc = cyc;
    if (!prev_err && error) err_rise_cyc = cyc;
    prev_den = drp_den;
    prev_rst = mmcm_rst;
    prev_err = error;
  endtask

  task automatic pulse_start();
    rd_seen = 0; wr_seen = 0; done_cnt = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_cfg(input int v, input bit poke);
    bit got_done = 1'b0, poked = 1'b0;
    cur = vecs[v];
    pulse_start();
    chk("accepted_busy", busy, 1'b1);
    chk("accepted_error_clear", error, 1'b0);
    chk("accepted_code_clear", err_code, 2'd0);
    for (int n = 0; n < 2000; n++) begin
      tick();
      start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        if (poke) start = 1'b1;
        break;
      end
      if (poke && !poked && wr_seen >= 1) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    tick();
    start = 1'b0;
    repeat (30) tick();
    chk("done_seen", got_done, 1'b1);
    chk("done_count", done_cnt, 1);
    chk("rst_hold_to_den", first_rd_cyc - rst_rise_cyc, 5);
    chk("reads", rd_seen, 2);
    chk("writes", wr_seen, 2);
    chk("sb_empty", sb_q.size(), 0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_error", error, 1'b0);
    chk("idle_code", err_code, 2'd0);
    chk("idle_mmcm_rst", mmcm_rst, 1'b0);
    $display("vector %0d: reads=%0d writes=%0d done=%0d errors so far=%0d", v, rd_seen, wr_seen, done_cnt, errors);
  endtask

  initial begin
    // fields: a0 m0 d0 e0 | a1 m1 d1 e1 | rd lat spur
    vecs[0] = '{7'h08, 16'h1000, 16'h0041, 16'h1041, 7'h09, 16'hFC00, 16'h0080, 16'hFC80, 16'hFFFF, 3, 1'b0};
    vecs[1] = '{7'h10, 16'h00FF, 16'h1234, 16'h1200, 7'h7F, 16'hFFFF, 16'hABCD, 16'h0000, 16'h0000, 2, 1'b0};
    vecs[2] = '{7'h28, 16'h0000, 16'h5A5A, 16'h5A5A, 7'h4E, 16'hF0F0, 16'h1234, 16'hA2A4, 16'hA5A5, 5, 1'b0};
    vecs[3] = '{7'h00, 16'h8001, 16'hFFFF, 16'h7FFE, 7'h55, 16'h0F00, 16'h0000, 16'h0C00, 16'h3C3C, 1, 1'b1};
    cur = vecs[0];
    reset = 1'b1; start = 1'b0; drp_drdy = 1'b0; drp_do = 16'h0; mmcm_locked = 1'b0;

    repeat (3) tick();
    chk("rst_mmcm_rst", mmcm_rst, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_code", err_code, 2'd0);
    chk("rst_idx", tbl_idx, 4'd0);
    chk("rst_den", drp_den, 1'b0);
    chk("rst_dwe", drp_dwe, 1'b0);
    chk("rst_daddr", drp_daddr, 7'd0);
    chk("rst_di", drp_di, 16'd0);
    chk("rst_locked_sync", locked_sync, 1'b0);
    reset = 1'b0;
    tick();
    chk("post_rst_mmcm_rst", mmcm_rst, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    repeat (5) tick();

    for (int v = 0; v < 4; v++) run_cfg(v, v == 1);

    // No DRDY on the first read: DRDY timeout, nothing written.
    cur = vecs[0];
    resp_en = 1'b0;
    pulse_start();
    for (int n = 0; n < 300; n++) begin
      tick();
      if (error) break;
    end
    chk("drdy_to_error", error, 1'b1);
    chk("drdy_to_code", err_code, 2'd1);
    chk("drdy_to_latency", err_rise_cyc - first_rd_cyc, 65);
    chk("drdy_to_mmcm_rst", mmcm_rst, 1'b0);
    chk("drdy_to_reads", rd_seen, 1);
    chk("drdy_to_writes", wr_seen, 0);
    tick();
    chk("drdy_to_busy", busy, 1'b0);
    $display("drdy timeout: code=%0d latency=%0d", err_code, err_rise_cyc - first_rd_cyc);
    resp_en = 1'b1;
    sb_q.delete();
    repeat (3) tick();

    // LOCKED never rises: lock timeout, then a clean retry.
    lock_en = 1'b0;
    pulse_start();
    for (int n = 0; n < 70000; n++) begin
      tick();
      if (error) break;
    end
    chk("lock_to_error", error, 1'b1);
    chk("lock_to_code", err_code, 2'd2);
    chk("lock_to_latency", err_rise_cyc - rst_fall_cyc, 65537);
    chk("lock_to_writes", wr_seen, 2);
    chk("lock_to_done", done_cnt, 0);
    $display("lock timeout: code=%0d latency=%0d", err_code, err_rise_cyc - rst_fall_cyc);
    lock_en = 1'b1;
    repeat (3) tick();
    run_cfg(0, 1'b0);

    // Reset while a read awaits DRDY; the late DRDY lands in IDLE.
    cur = vecs[0];
    pulse_start();
    for (int n = 0; n < 50; n++) begin
      tick();
      if (rd_seen == 1) break;
    end
    chk("mid_rst_read_issued", rd_seen, 1);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_mmcm_rst", mmcm_rst, 1'b1);
    chk("mid_rst_den", drp_den, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    reset = 1'b0;
    sb_q.delete();
    repeat (10) tick();
    chk("mid_rst_reads", rd_seen, 1);
    chk("mid_rst_writes", wr_seen, 0);
    chk("mid_rst_busy_after", busy, 1'b0);
    chk("mid_rst_done", done_cnt, 0);
    chk("mid_rst_error", error, 1'b0);
    chk("mid_rst_code", err_code, 2'd0);
    chk("mid_rst_idx", tbl_idx, 4'd0);
    chk("mid_rst_daddr", drp_daddr, 7'd0);
    chk("mid_rst_di", drp_di, 16'd0);
    chk("mid_rst_mmcm_rst_low", mmcm_rst, 1'b0);
    $display("reset mid-read: reads=%0d writes=%0d busy=%0d", rd_seen, wr_seen, busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
